// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Purpose  : Request, response and ALU-side signals of the ALU sequencer.
//            The slave modport is the sequencer's view; the master modport
//            is the view of whatever surrounds it (upstream, ALU, consumer).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    // upstream request channel
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_operation;
    logic [31:0] in_operand_a;
    logic [31:0] in_operand_b;

    // downstream ALU
    logic [3:0]  alu_operation;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [31:0] alu_result;
    logic [1:0]  alu_error_flag;

    // result channel
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_error_flag;

    modport slave (
        input  in_valid, in_operation, in_operand_a, in_operand_b,
        input  alu_result, alu_error_flag, out_ready,
        output in_ready, alu_operation, alu_operand_a, alu_operand_b,
        output out_valid, out_result, out_error_flag
    );

    modport master (
        output in_valid, in_operation, in_operand_a, in_operand_b,
        output alu_result, alu_error_flag, out_ready,
        input  in_ready, alu_operation, alu_operand_a, alu_operand_b,
        input  out_valid, out_result, out_error_flag
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Accepts one ALU request at a time, holds the operands on the
//            ALU inputs, waits extra settle cycles for DIV, captures the
//            ALU result/flag and presents it until the consumer takes it.
//            Keeps a saturating count of captured results with an error.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int DIV_WAIT = 4      // extra settle cycles for DIV, 0..15
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_sequencer_if.slave   bus,
    output logic             busy,
    output logic [7:0]       error_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_exec = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [3:0] c_op_div      = 4'b0110;
    localparam logic [3:0] c_op_legal_lo = 4'd3;
    localparam logic [3:0] c_op_legal_hi = 4'd12;

    localparam bit         c_has_wait  = (DIV_WAIT > 0);
    localparam logic [3:0] c_wait_load = 4'(c_has_wait ? DIV_WAIT - 1 : 0);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  r_alu_operation;
    logic [31:0] r_alu_operand_a;
    logic [31:0] r_alu_operand_b;
    logic [31:0] r_out_result;
    logic [1:0]  r_out_error_flag;
    logic [7:0]  r_error_count;

    logic        w_accept;
    logic        w_to_wait;
    logic        w_flag_passes;
    logic [1:0]  w_capture_flag;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_busy;

    assign w_accept  = (r_state == c_st_idle) && bus.in_valid;
    assign w_to_wait = (bus.in_operation == c_op_div) && c_has_wait;

    // Only DIV and illegal opcodes can report an ALU error; every other
    // opcode gets a clean flag so nothing stale can leak through.
    assign w_flag_passes  = (r_alu_operation == c_op_div)
                         || (r_alu_operation < c_op_legal_lo)
                         || (r_alu_operation > c_op_legal_hi);
    assign w_capture_flag = w_flag_passes ? bus.alu_error_flag : 2'b00;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.in_valid) begin
                    w_state_next = w_to_wait ? c_st_wait : c_st_exec;
                end
            end
            c_st_wait: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = c_st_exec;
                end
            end
            c_st_exec: begin
                w_state_next = c_st_done;
            end
            c_st_done: begin
                if (bus.out_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            c_st_idle: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
            end
            c_st_done: begin
                w_out_valid = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // DIV settle counter: loaded on acceptance, counts down while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (w_accept && w_to_wait) begin
            r_wait_cnt <= c_wait_load;
        end else if ((r_state == c_st_wait) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // ALU operand registers: change only on an accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_operation <= 4'd0;
            r_alu_operand_a <= 32'd0;
            r_alu_operand_b <= 32'd0;
        end else if (w_accept) begin
            r_alu_operation <= bus.in_operation;
            r_alu_operand_a <= bus.in_operand_a;
            r_alu_operand_b <= bus.in_operand_b;
        end
    end

    // Result capture in EXEC and saturating error tally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_result     <= 32'd0;
            r_out_error_flag <= 2'b00;
            r_error_count    <= 8'd0;
        end else if (r_state == c_st_exec) begin
            r_out_result     <= bus.alu_result;
            r_out_error_flag <= w_capture_flag;
            if ((w_capture_flag != 2'b00) && (r_error_count != 8'hFF)) begin
                r_error_count <= r_error_count + 8'd1;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.alu_operation  = r_alu_operation;
    assign bus.alu_operand_a  = r_alu_operand_a;
    assign bus.alu_operand_b  = r_alu_operand_b;
    assign bus.out_result     = r_out_result;
    assign bus.out_error_flag = r_out_error_flag;
    assign busy               = w_busy;
    assign error_count        = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer with a small
//            combinational ALU stub behind the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [3:0] c_op_add = 4'd3;
    localparam logic [3:0] c_op_sub = 4'd4;
    localparam logic [3:0] c_op_div = 4'b0110;
    localparam logic [3:0] c_op_and = 4'd7;
    localparam logic [3:0] c_op_bad = 4'b1111;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [7:0] error_count;
    int         n_cmp;
    int         n_bad;

    alu_sequencer_if bus ();

    alu_sequencer #(.DIV_WAIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .error_count (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub; ordinary ops drive a junk flag so a leaked flag is visible
    always_comb begin
        bus.alu_result     = 32'd0;
        bus.alu_error_flag = 2'b11;
        case (bus.alu_operation)
            c_op_add: bus.alu_result = bus.alu_operand_a + bus.alu_operand_b;
            c_op_sub: bus.alu_result = bus.alu_operand_a - bus.alu_operand_b;
            c_op_and: bus.alu_result = bus.alu_operand_a & bus.alu_operand_b;
            c_op_div: begin
                if (bus.alu_operand_b == 32'd0) begin
                    bus.alu_error_flag = 2'b01;
                end else begin
                    bus.alu_result     = bus.alu_operand_a / bus.alu_operand_b;
                    bus.alu_error_flag = 2'b00;
                end
            end
            default: begin
                if ((bus.alu_operation < 4'd3) || (bus.alu_operation > 4'd12)) begin
                    bus.alu_error_flag = 2'b10;
                end
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request now, then follow it to DONE (and back to IDLE when
    // out_ready is high). Ends on a falling edge.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic [1:0] exp_flag);
        int lat;
        bus.in_valid     = 1'b1;
        bus.in_operation = op;
        bus.in_operand_a = a;
        bus.in_operand_b = b;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 40);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, bus.out_result, exp_res);
        check({tag, "_flag"}, 32'(bus.out_error_flag), 32'(exp_flag));
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp            = 0;
        n_bad            = 0;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_operation = 4'd0;
        bus.in_operand_a = 32'd0;
        bus.in_operand_b = 32'd0;
        bus.out_ready    = 1'b1;

        // values while reset is held
        #7;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_flag", 32'(bus.out_error_flag), 32'd0);
        check("rst_err_cnt", 32'(error_count), 32'd0);
        check("rst_alu_op", 32'(bus.alu_operation), 32'd0);
        check("rst_alu_a", bus.alu_operand_a, 32'd0);
        check("rst_alu_b", bus.alu_operand_b, 32'd0);

        // release between edges; the very next rising edge accepts the ADD
        #5;
        reset = 1'b0;
        run_op("add", c_op_add, 32'd7, 32'd5, 1, 32'd12, 2'b00);
        check("add_err_cnt", 32'(error_count), 32'd0);

        run_op("div", c_op_div, 32'd100, 32'd7, 5, 32'd14, 2'b00);
        check("div_err_cnt", 32'(error_count), 32'd0);

        run_op("div0", c_op_div, 32'd9, 32'd0, 5, 32'd0, 2'b01);
        check("div0_err_cnt", 32'(error_count), 32'd1);

        run_op("and", c_op_and, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000, 2'b00);
        check("and_err_cnt", 32'(error_count), 32'd1);

        run_op("bad", c_op_bad, 32'd1, 32'd2, 1, 32'd0, 2'b10);
        check("bad_err_cnt", 32'(error_count), 32'd2);

        for (int i = 0; i < 300; i++) begin
            run_op("sat", c_op_bad, 32'(i), 32'd3, 1, 32'd0, 2'b10);
        end
        check("sat_err_cnt", 32'(error_count), 32'd255);

        // hold a SUB result while the upstream keeps poking
        bus.out_ready = 1'b0;
        run_op("sub", c_op_sub, 32'd50, 32'd8, 1, 32'd42, 2'b00);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid     = i[0];
            bus.in_operation = c_op_add;
            bus.in_operand_a = 32'(1000 + i);
            bus.in_operand_b = 32'd1;
            @(posedge clk);
            #1;
            check("hold_result", bus.out_result, 32'd42);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_alu_a", bus.alu_operand_a, 32'd50);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_ready", 32'(bus.in_ready), 32'd1);
        check("hold_release_alu_a", bus.alu_operand_a, 32'd50);
        @(negedge clk);

        // reset in the middle of a DIV settle period
        bus.in_valid     = 1'b1;
        bus.in_operation = c_op_div;
        bus.in_operand_a = 32'd77;
        bus.in_operand_b = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midwait_busy", 32'(busy), 32'd1);
        check("midwait_cnt", 32'(dut.r_wait_cnt), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", bus.out_result, 32'd0);
        check("arst_flag", 32'(bus.out_error_flag), 32'd0);
        check("arst_err_cnt", 32'(error_count), 32'd0);
        check("arst_alu_op", 32'(bus.alu_operation), 32'd0);
        check("arst_alu_a", bus.alu_operand_a, 32'd0);
        check("arst_alu_b", bus.alu_operand_b, 32'd0);
        check("arst_cnt", 32'(dut.r_wait_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst_add", c_op_add, 32'd1, 32'd2, 1, 32'd3, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
